// File: rtl/lcd_i2c_sequencer.sv
`timescale 1ns/1ps
// Purpose: round-robin scheduler turning {rs,byte} LCD requests from two clients into four PCF8574 I2C frames plus a settle delay.
// Latency: ready is a same-cycle accept; first i2c_ena the cycle after accept; done one settle delay after the last busy fall.
// Backpressure: one request in flight; the other requester waits with valid held until its ready strobe.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   reqN_valid/rs/data       requester N byte offer (N = 0, 1)
//   reqN_ready               one-cycle accept strobe back to requester N
//   i2c_ena/i2c_data_wr      frame start and PCF8574 byte to i2c_master
//   i2c_busy                 i2c_master busy
//   done/done_id             one-cycle completion pulse and the finished requester
//   active                   request in flight
//   err_timeout              sticky handshake-timeout flag
module lcd_i2c_sequencer #(
    parameter int   CMD_DELAY_CYC = 5_000,
    parameter int   CLR_DELAY_CYC = 200_000,
    parameter int   TIMEOUT_CYC   = 100_000,
    parameter logic BACKLIGHT     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       i2c_ena,
    output logic [7:0] i2c_data_wr,
    input  logic       i2c_busy,
    output logic       done,
    output logic       done_id,
    output logic       active,
    output logic       err_timeout
);

    localparam int MAX_A = (CMD_DELAY_CYC > CLR_DELAY_CYC) ? CMD_DELAY_CYC : CLR_DELAY_CYC;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CW    = $clog2(MAX_C) + 1;

    // Terminal counts: the counter starts at 0 on state entry, so N cycles end at N-1.
    localparam logic [CW-1:0] CMD_TERM = CW'(CMD_DELAY_CYC - 1);
    localparam logic [CW-1:0] CLR_TERM = CW'(CLR_DELAY_CYC - 1);
    localparam logic [CW-1:0] TO_TERM  = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FRAME_REQ  = 2'd1,
        S_FRAME_WAIT = 2'd2,
        S_SETTLE     = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_idx;
    logic            r_rs;
    logic [7:0]      r_data;
    logic            r_grant;
    logic            r_last;      // requester granted most recently; reset value 1 favours req0
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    logic            w_gnt_vld;
    logic            w_gnt_id;
    logic            w_accept;
    logic            w_done;
    logic            w_abort;
    logic            w_is_clr;
    logic            w_settle_end;
    logic            w_to;
    logic [3:0]      w_nib;

    // Round-robin: with both requesters valid, the one not granted last wins.
    always_comb begin
        w_gnt_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_gnt_id = ~r_last;
        end else begin
            w_gnt_id = req1_valid;
        end
    end

    // Clear display / return home need the long settle time.
    assign w_is_clr     = ~r_rs && (r_data >= 8'h01) && (r_data <= 8'h03);
    assign w_settle_end = w_is_clr ? (r_cnt == CLR_TERM) : (r_cnt == CMD_TERM);
    assign w_to         = (r_cnt == TO_TERM);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_accept = 1'b1;
                    w_next   = S_FRAME_REQ;
                end
            end
            S_FRAME_REQ: begin
                if (i2c_busy) begin
                    w_next = S_FRAME_WAIT;
                end else if (w_to) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_FRAME_WAIT: begin
                if (!i2c_busy) begin
                    w_next = (r_idx == 2'd3) ? S_SETTLE : S_FRAME_REQ;
                end else if (w_to) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (w_settle_end) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Frames 0/1 carry the high nibble, 2/3 the low nibble; EN is high on even frames.
    assign w_nib = r_idx[1] ? r_data[3:0] : r_data[7:4];

    assign req0_ready  = w_accept & ~w_gnt_id & ~rst;
    assign req1_ready  = w_accept &  w_gnt_id & ~rst;
    assign i2c_ena     = (r_state == S_FRAME_REQ) & ~rst;
    assign i2c_data_wr = ((r_state == S_FRAME_REQ || r_state == S_FRAME_WAIT) && !rst)
                         ? {w_nib, BACKLIGHT, ~r_idx[0], 1'b0, r_rs} : 8'h00;
    assign done        = w_done & ~rst;
    assign done_id     = w_done & r_grant & ~rst;
    assign active      = (r_state != S_IDLE);
    assign err_timeout = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counter restarts on every state entry and idles at zero.
            if (w_next != r_state || w_next == S_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_grant <= w_gnt_id;
                r_rs    <= w_gnt_id ? req1_rs   : req0_rs;
                r_data  <= w_gnt_id ? req1_data : req0_data;
            end
            if (r_state == S_FRAME_WAIT && !i2c_busy) begin
                r_idx <= r_idx + 2'd1;   // 3 wraps to 0 on entry to SETTLE
            end
            if (w_abort) begin
                r_idx <= 2'd0;
                r_err <= 1'b1;
            end
            if (w_done) begin
                r_last <= r_grant;
            end
        end
    end

endmodule

// File: tb/tb_lcd_i2c_sequencer.sv
`timescale 1ns/1ps
module tb_lcd_i2c_sequencer;

    localparam int CMD = 20;
    localparam int CLR = 60;
    localparam int TO  = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_rs, req1_valid, req1_rs;
    logic [7:0] req0_data, req1_data;
    logic       busy;

    logic       r0_a, r1_a, ena_a, done_a, did_a, act_a, err_a;
    logic [7:0] dwr_a;
    logic       r0_b, r1_b, ena_b, done_b, did_b, act_b, err_b;
    logic [7:0] dwr_b;

    lcd_i2c_sequencer #(.CMD_DELAY_CYC(CMD), .CLR_DELAY_CYC(CLR), .TIMEOUT_CYC(TO), .BACKLIGHT(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(r0_a),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(r1_a),
        .i2c_ena(ena_a), .i2c_data_wr(dwr_a), .i2c_busy(busy),
        .done(done_a), .done_id(did_a), .active(act_a), .err_timeout(err_a));

    // Same stimulus, backlight off: runs in lockstep with dut_a.
    lcd_i2c_sequencer #(.CMD_DELAY_CYC(CMD), .CLR_DELAY_CYC(CLR), .TIMEOUT_CYC(TO), .BACKLIGHT(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(r0_b),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(r1_b),
        .i2c_ena(ena_b), .i2c_data_wr(dwr_b), .i2c_busy(busy),
        .done(done_b), .done_id(did_b), .active(act_b), .err_timeout(err_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] fa; logic [7:0] fb; } frm_t;
    typedef struct { logic id; int dly; } dn_t;
    frm_t exp_frm[$];
    dn_t  exp_done[$];
    logic exp_gnt[$];

    int checks = 0;
    int passed = 0;
    int nfr = 0, ndone = 0, ngnt = 0;
    int rise_cyc = 0;
    int last_fall = 0;
    logic bus_hang = 1'b0;
    logic prev_ena = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_frm(input logic [7:0] a, input logic [7:0] b);
        frm_t f;
        f.fa = a; f.fb = b;
        exp_frm.push_back(f);
    endtask

    task automatic push_done(input logic id, input int dly);
        dn_t d;
        d.id = id; d.dly = dly;
        exp_done.push_back(d);
    endtask

    // i2c_master model: busy one cycle after ena, held 10 cycles.
    int bcnt = 0;
    initial begin
        busy = 1'b0;
        forever begin
            tick();
            if (rst) begin
                busy = 1'b0; bcnt = 0;
            end else if (busy) begin
                bcnt--;
                if (bcnt == 0) begin busy = 1'b0; last_fall = cyc; end
            end else if (ena_a && !bus_hang) begin
                busy = 1'b1; bcnt = 10;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (ena_a && !prev_ena) begin
            nfr++;
            rise_cyc = cyc;
            if (exp_frm.size() == 0) begin
                chk("unexpected_frame", int'(dwr_a), -1);
            end else begin
                frm_t f;
                f = exp_frm.pop_front();
                chk("frame_bl1", int'(dwr_a), int'(f.fa));
                chk("frame_bl0", int'(dwr_b), int'(f.fb));
            end
        end
        prev_ena = ena_a;
        if (r0_a || r1_a) begin
            ngnt++;
            chk("ready_onehot", int'(r0_a & r1_a), 0);
            if (exp_gnt.size() == 0) begin
                chk("unexpected_grant", int'(r1_a), -1);
            end else begin
                logic g;
                g = exp_gnt.pop_front();
                chk("grant_id", int'(r1_a), int'(g));
                chk("grant_id_b", int'(r1_b), int'(g));
            end
        end
        if (done_a) begin
            ndone++;
            if (exp_done.size() == 0) begin
                chk("unexpected_done", int'(did_a), -1);
            end else begin
                dn_t d;
                d = exp_done.pop_front();
                chk("done_id", int'(did_a), int'(d.id));
                chk("done_b_id", int'(did_b), int'(d.id));
                chk("done_b", int'(done_b), 1);
                chk("settle_cycles", cyc - last_fall, d.dly);
            end
        end
    end

    task automatic send(input logic id, input logic rs, input logic [7:0] d);
        int k;
        logic seen;
        tick();
        if (id) begin req1_valid = 1'b1; req1_rs = rs; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_rs = rs; req0_data = d; end
        seen = 1'b0;
        k = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            seen = id ? r1_a : r0_a;
            k++;
        end
        if (!seen) chk("accept_wait", 0, 1);
        tick();
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (ndone < n && k < 3000) begin @(negedge clk); k++; end
        chk("done_count", ndone, n);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        rst = 1'b1;
        req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ena", int'(ena_a), 0);
        chk("rst_data", int'(dwr_a), 0);
        chk("rst_active", int'(act_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_ready", int'(r0_a | r1_a), 0);
        tick();
        rst = 1'b0;

        // 1: data 'H'
        exp_gnt.push_back(1'b0);
        push_frm(8'h4D, 8'h45); push_frm(8'h49, 8'h41); push_frm(8'h8D, 8'h85); push_frm(8'h89, 8'h81);
        push_done(1'b0, CMD);
        send(1'b0, 1'b1, 8'h48);
        wait_done(1);

        // 2: clear display, long settle
        exp_gnt.push_back(1'b0);
        push_frm(8'h0C, 8'h04); push_frm(8'h08, 8'h00); push_frm(8'h1C, 8'h14); push_frm(8'h18, 8'h10);
        push_done(1'b0, CLR);
        send(1'b0, 1'b0, 8'h01);
        wait_done(2);

        // 6: requester 1, backlight on/off variants
        exp_gnt.push_back(1'b1);
        push_frm(8'h2D, 8'h25); push_frm(8'h29, 8'h21); push_frm(8'h1D, 8'h15); push_frm(8'h19, 8'h11);
        push_done(1'b1, CMD);
        send(1'b1, 1'b1, 8'h21);
        wait_done(3);

        // 4: bus never answers
        bus_hang = 1'b1;
        exp_gnt.push_back(1'b0);
        push_frm(8'h3D, 8'h35);
        send(1'b0, 1'b1, 8'h30);
        k = 0;
        while (!err_a && k < TO + 50) begin @(negedge clk); k++; end
        chk("timeout_flag", int'(err_a), 1);
        chk("timeout_latency", cyc - rise_cyc, TO);
        chk("timeout_ena", int'(ena_a), 0);
        chk("timeout_active", int'(act_a), 0);
        chk("timeout_flag_b", int'(err_b), 1);
        repeat (30) @(negedge clk);
        chk("no_done_after_abort", ndone, 3);
        bus_hang = 1'b0;
        exp_gnt.push_back(1'b0);
        push_frm(8'h4D, 8'h45); push_frm(8'h49, 8'h41); push_frm(8'h8D, 8'h85); push_frm(8'h89, 8'h81);
        push_done(1'b0, CMD);
        send(1'b0, 1'b1, 8'h48);
        wait_done(4);
        chk("timeout_sticky", int'(err_a), 1);

        // 5: reset during frame 2
        exp_gnt.push_back(1'b0);
        push_frm(8'h4D, 8'h45); push_frm(8'h49, 8'h41); push_frm(8'h8D, 8'h85);
        base = nfr;
        send(1'b0, 1'b1, 8'h48);
        k = 0;
        while (nfr < base + 3 && k < 200) begin @(negedge clk); k++; end
        chk("reached_frame2", nfr - base, 3);
        tick();
        rst = 1'b1;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_ena", int'(ena_a), 0);
        chk("midrst_active", int'(act_a), 0);
        chk("midrst_ready", int'(r0_a | r1_a), 0);
        chk("midrst_err_clear", int'(err_a), 0);
        exp_gnt.push_back(1'b0);
        push_frm(8'h4D, 8'h45); push_frm(8'h49, 8'h41); push_frm(8'h1D, 8'h15); push_frm(8'h19, 8'h11);
        push_done(1'b0, CMD);
        tick();
        rst = 1'b0;
        k = 0;
        while (!r0_a && k < 50) begin @(negedge clk); k++; end
        chk("restart_accept", int'(r0_a), 1);
        tick();
        req0_valid = 1'b0;
        wait_done(5);

        // 3: both requesters held, fresh pointer
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_gnt.push_back(i[0]);
            if (i[0]) begin
                push_frm(8'h8D, 8'h85); push_frm(8'h89, 8'h81); push_frm(8'h2D, 8'h25); push_frm(8'h29, 8'h21);
            end else begin
                push_frm(8'h4D, 8'h45); push_frm(8'h49, 8'h41); push_frm(8'h1D, 8'h15); push_frm(8'h19, 8'h11);
            end
            push_done(i[0], CMD);
        end
        base = ngnt;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h82;
        k = 0;
        while (ngnt < base + 4 && k < 2000) begin @(negedge clk); k++; end
        chk("rr_grants", ngnt - base, 4);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_done(9);

        repeat (20) @(negedge clk);
        chk("frames_left", exp_frm.size(), 0);
        chk("grants_left", exp_gnt.size(), 0);
        chk("dones_left", exp_done.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
